// File: rtl/sb_tx_arbiter.sv
// rtl/sb_tx_arbiter.sv - round-robin arbiter sharing one sideband TX message port among LTSM requesters
package sb_tx_pkg;
    typedef logic [7:0] SB_msg_t;
endpackage

module sb_tx_arbiter
    import sb_tx_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OWN_W = $clog2(N_REQ)
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_valid_i,
    input  SB_msg_t           req_msg_i [N_REQ],
    input  logic [63:0]       req_data_i [N_REQ],
    output logic [N_REQ-1:0]  req_grant_o,
    output logic [N_REQ-1:0]  req_done_o,
    output logic [N_REQ-1:0]  req_timeout_o,
    output SB_msg_t           SB_TX_msg_o,
    output logic [63:0]       SB_TX_dataBus_o,
    output logic              SB_TX_msg_valid_o,
    input  logic              SB_TX_msg_sendNextFlag_i,
    input  logic              SBmessage_retry_timeout_flag,
    output logic              reset_SBmessage_retry_timeout,
    output logic [OWN_W-1:0]  owner_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OWN_W-1:0]   rr_ptr_q;
    logic [OWN_W-1:0]   owner_q;
    SB_msg_t            msg_q;
    logic [63:0]        data_q;
    logic               first_q;

    logic [OWN_W-1:0]   win_idx;
    logic               win_found;
    logic [OWN_W:0]     cand;
    logic               load;
    logic               done_ev;
    logic               tmo_ev;
    logic [N_REQ-1:0]   owner_oh;
    logic [OWN_W-1:0]   rr_next;

    // Search starts at rr_ptr and wraps, so the last owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (OWN_W+1)'(i);
            if (cand >= (OWN_W+1)'(N_REQ)) begin
                cand = cand - (OWN_W+1)'(N_REQ);
            end
            if (!win_found && req_valid_i[cand[OWN_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OWN_W-1:0];
            end
        end
    end

    // sendNext has priority over timeout; both are ignored outside SEND.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_ev = 1'b0;
        tmo_ev  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (SB_TX_msg_sendNextFlag_i) begin
                    done_ev = 1'b1;
                    state_d = GAP;
                end else if (SBmessage_retry_timeout_flag) begin
                    tmo_ev  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign rr_next = (owner_q == OWN_W'(N_REQ-1)) ? '0 : owner_q + OWN_W'(1);

    // A message caught by reset is discarded, so completion pulses are gated by reset.
    assign req_grant_o                   = (state_q == SEND) ? owner_oh : '0;
    assign req_done_o                    = (done_ev && reset) ? owner_oh : '0;
    assign req_timeout_o                 = (tmo_ev && reset) ? owner_oh : '0;
    assign SB_TX_msg_valid_o             = (state_q == SEND);
    assign busy_o                        = (state_q == SEND);
    assign SB_TX_msg_o                   = msg_q;
    assign SB_TX_dataBus_o               = data_q;
    assign owner_o                       = owner_q;
    assign reset_SBmessage_retry_timeout = first_q;

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            msg_q    <= '0;
            data_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= load;
            if (load) begin
                owner_q <= win_idx;
                msg_q   <= req_msg_i[win_idx];
                data_q  <= req_data_i[win_idx];
            end
            if (done_ev || tmo_ev) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb/tb_sb_tx_arbiter.sv - directed vector bench for sb_tx_arbiter
module tb_sb_tx_arbiter;
    import sb_tx_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    SB_msg_t     req_msg [4];
    logic [63:0] req_data [4];
    logic [3:0]  grant, done, tmo;
    SB_msg_t     tx_msg;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        send_next;
    logic        tmo_flag;
    logic        rst_timer;
    logic [1:0]  owner;
    logic        busy;

    int checks;
    int failures;

    sb_tx_arbiter #(.N_REQ(4)) dut (
        .clk_100MHz                    (clk),
        .reset                         (reset),
        .req_valid_i                   (req_valid),
        .req_msg_i                     (req_msg),
        .req_data_i                    (req_data),
        .req_grant_o                   (grant),
        .req_done_o                    (done),
        .req_timeout_o                 (tmo),
        .SB_TX_msg_o                   (tx_msg),
        .SB_TX_dataBus_o               (tx_data),
        .SB_TX_msg_valid_o             (tx_valid),
        .SB_TX_msg_sendNextFlag_i      (send_next),
        .SBmessage_retry_timeout_flag  (tmo_flag),
        .reset_SBmessage_retry_timeout (rst_timer),
        .owner_o                       (owner),
        .busy_o                        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       snd;
        logic       tf;
        logic [3:0] e_gnt;
        logic [3:0] e_done;
        logic [3:0] e_tmo;
        logic       e_val;
        logic       e_rt;
        logic [1:0] e_own;
        logic       e_busy;
        logic       e_pay;
    } vec_t;

    vec_t v [27];

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic snd,
                                input logic tf, input logic [3:0] g, input logic [3:0] d,
                                input logic [3:0] t, input logic val, input logic rt,
                                input logic [1:0] own, input logic bsy, input logic pay);
        vec_t r;
        r.rst = rst; r.vld = vld; r.snd = snd; r.tf = tf;
        r.e_gnt = g; r.e_done = d; r.e_tmo = t; r.e_val = val; r.e_rt = rt;
        r.e_own = own; r.e_busy = bsy; r.e_pay = pay;
        return r;
    endfunction

    task automatic chk(input string name, input int ctx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0d: got %h expected %h", name, ctx, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic init_payload();
        for (int i = 0; i < 4; i++) begin
            req_msg[i]  = 8'h10 + 8'(i);
            req_data[i] = 64'hDA7A_0000_0000_0000 + 64'(i);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        req_valid = 4'b0000;
        send_next = 1'b0;
        tmo_flag  = 1'b0;
        init_payload();

        //          rst vld     snd tf  gnt     done    tmo     val rt own  bsy pay
        v[0]  = mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 0);
        v[1]  = mk(1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 0);
        v[2]  = mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 1, 2'd0, 1, 1);
        v[3]  = mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 1, 1);
        v[4]  = mk(1, 4'b0001, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 2'd0, 1, 1);
        v[5]  = mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[6]  = mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[7]  = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 0);
        v[8]  = mk(1, 4'b1111, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 2'd0, 1, 1);
        v[9]  = mk(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[10] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[11] = mk(1, 4'b1111, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 2'd1, 1, 1);
        v[12] = mk(1, 4'b1111, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1);
        v[13] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1);
        v[14] = mk(1, 4'b1111, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 2'd2, 1, 1);
        v[15] = mk(1, 4'b1111, 0, 1, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2'd2, 1, 1);
        v[16] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd2, 0, 1);
        v[17] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd2, 0, 1);
        v[18] = mk(1, 4'b1111, 1, 1, 4'b1000, 4'b1000, 4'b0000, 1, 1, 2'd3, 1, 1);
        v[19] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd3, 0, 1);
        v[20] = mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd3, 0, 1);
        v[21] = mk(1, 4'b1111, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 2'd0, 1, 1);
        v[22] = mk(1, 4'b0011, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[23] = mk(1, 4'b0011, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1);
        v[24] = mk(1, 4'b0011, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 2'd1, 1, 1);
        v[25] = mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1);
        v[26] = mk(1, 4'b0000, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1);

        repeat (2) next_cycle();

        for (int k = 0; k < 27; k++) begin
            reset     = v[k].rst;
            req_valid = v[k].vld;
            send_next = v[k].snd;
            tmo_flag  = v[k].tf;
            @(negedge clk);
            chk("grant",   k, 64'(grant),     64'(v[k].e_gnt));
            chk("done",    k, 64'(done),      64'(v[k].e_done));
            chk("timeout", k, 64'(tmo),       64'(v[k].e_tmo));
            chk("valid",   k, 64'(tx_valid),  64'(v[k].e_val));
            chk("rtimer",  k, 64'(rst_timer), 64'(v[k].e_rt));
            chk("owner",   k, 64'(owner),     64'(v[k].e_own));
            chk("busy",    k, 64'(busy),      64'(v[k].e_busy));
            if (v[k].e_pay) begin
                chk("msg",  k, 64'(tx_msg), 64'(8'h10 + 8'(v[k].e_own)));
                chk("data", k, tx_data, 64'hDA7A_0000_0000_0000 + 64'(v[k].e_own));
            end else begin
                chk("msg0",  k, 64'(tx_msg), 64'd0);
                chk("data0", k, tx_data, 64'd0);
            end
            next_cycle();
        end

        // Payload stability: owner 2 changes its inputs and drops valid mid-SEND.
        send_next = 1'b0;
        tmo_flag  = 1'b0;
        req_valid = 4'b0100;
        next_cycle();
        req_valid   = 4'b0000;
        req_data[2] = 64'h5555_5555_5555_5555;
        req_msg[2]  = 8'hEE;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) send_next = 1'b1;
            @(negedge clk);
            chk("stab_valid", 100 + c, 64'(tx_valid), 64'd1);
            chk("stab_grant", 100 + c, 64'(grant), 64'(4'b0100));
            chk("stab_data",  100 + c, tx_data, 64'hDA7A_0000_0000_0002);
            chk("stab_msg",   100 + c, 64'(tx_msg), 64'h12);
            next_cycle();
        end
        send_next = 1'b0;
        @(negedge clk);
        chk("stab_gap_valid", 103, 64'(tx_valid), 64'd0);
        chk("stab_gap_data",  103, tx_data, 64'hDA7A_0000_0000_0002);
        init_payload();
        next_cycle();

        // Reset mid-SEND with sendNext high: owner 1 is discarded silently.
        req_valid = 4'b0010;
        next_cycle();
        reset     = 1'b0;
        send_next = 1'b1;
        @(negedge clk);
        chk("rst_pre_grant", 200, 64'(grant), 64'(4'b0010));
        chk("rst_pre_done",  200, 64'(done), 64'd0);
        chk("rst_pre_tmo",   200, 64'(tmo), 64'd0);
        next_cycle();
        reset     = 1'b1;
        send_next = 1'b0;
        req_valid = 4'b0110;
        @(negedge clk);
        chk("rst_grant",  201, 64'(grant), 64'd0);
        chk("rst_valid",  201, 64'(tx_valid), 64'd0);
        chk("rst_busy",   201, 64'(busy), 64'd0);
        chk("rst_owner",  201, 64'(owner), 64'd0);
        chk("rst_rtimer", 201, 64'(rst_timer), 64'd0);
        chk("rst_msg",    201, 64'(tx_msg), 64'd0);
        chk("rst_data",   201, tx_data, 64'd0);
        chk("rst_done",   201, 64'(done), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_grant", 202, 64'(grant), 64'(4'b0010));
        chk("post_rst_owner", 202, 64'(owner), 64'd1);
        chk("post_rst_data",  202, tx_data, 64'hDA7A_0000_0000_0001);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of LTSM requesters (2..8) sharing the single sideband TX message port.
REQ-002 Parameter OWN_W, default $clog2(N_REQ), is the width of the owner index.
REQ-003 clk_100MHz  input  1  sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid_i  input  N_REQ  per-requester request to send one message.
REQ-006 req_msg_i  input  N_REQ x SB_msg_t  per-requester message code.
REQ-007 req_data_i  input  N_REQ x 64  per-requester data payload.
REQ-008 req_grant_o  output  N_REQ  one-hot, high while that requester owns the port.
REQ-009 req_done_o  output  N_REQ  one-cycle pulse when the owner's message is accepted.
REQ-010 req_timeout_o  output  N_REQ  one-cycle pulse when the owner's message times out.
REQ-011 SB_TX_msg_o  output  SB_msg_t  message to the sideband TX.
REQ-012 SB_TX_dataBus_o  output  64  payload to the sideband TX.
REQ-013 SB_TX_msg_valid_o  output  1  message valid to the sideband TX.
REQ-014 SB_TX_msg_sendNextFlag_i  input  1  sideband TX has accepted the current message.
REQ-015 SBmessage_retry_timeout_flag  input  1  retry timer has expired.
REQ-016 reset_SBmessage_retry_timeout  output  1  one-cycle pulse that restarts the retry timer.
REQ-017 owner_o  output  OWN_W  index of the current or last owner.
REQ-018 busy_o  output  1  high in the SEND state.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-020 IDLE: if any req_valid_i bit is high, the FSM SHALL select a winner by round-robin starting at rr_ptr.
  - The selection SHALL latch the winner's req_msg_i and req_data_i into holding registers.
  - The FSM SHALL enter SEND on the next cycle.
REQ-021 Grant latency SHALL be exactly 1 cycle: request in cycle t gives req_grant_o and SB_TX_msg_valid_o high in cycle t+1.
REQ-022 reset_SBmessage_retry_timeout SHALL pulse high for exactly the first SEND cycle of each grant.
REQ-023 SEND: SB_TX_msg_o, SB_TX_dataBus_o and SB_TX_msg_valid_o=1 SHALL come from the holding registers.
  - They SHALL stay stable for the whole grant.
  - Changes on req_* inputs SHALL NOT affect them, including deassertion of the owner's req_valid_i.
REQ-024 SEND with SB_TX_msg_sendNextFlag_i=1 SHALL, in the same cycle:
  - pulse req_done_o[owner];
  - clear valid and grant on the next cycle;
  - set rr_ptr to (owner+1) mod N_REQ;
  - go to GAP.
REQ-025 SEND with SBmessage_retry_timeout_flag=1 and sendNextFlag=0 SHALL:
  - pulse req_timeout_o[owner];
  - release the port the same way as REQ-024;
  - go to GAP.
REQ-026 If sendNextFlag and the timeout flag are high in the same cycle, the FSM SHALL treat it as done only; no timeout pulse.
REQ-027 SendNextFlag or the timeout flag seen in IDLE or GAP SHALL be ignored.
REQ-028 GAP SHALL last exactly 1 cycle with valid=0, then go to IDLE, so consecutive messages have at least one idle cycle between them.
REQ-029 SB_TX_msg_valid_o SHALL be 0 in IDLE and GAP, and SB_TX_msg_o/SB_TX_dataBus_o SHALL hold their last values there.
REQ-030 Round-robin SHALL search indices rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Index N_REQ-1 SHALL wrap to 0.
  - No requester with valid held high SHALL wait more than N_REQ-1 other grants.
REQ-031 req_grant_o, req_done_o and req_timeout_o SHALL always be one-hot or zero.
REQ-032 If the owner re-asserts a request after done, it SHALL become lowest priority for the next arbitration.

Reset
REQ-033 reset=0 at a rising edge SHALL, regardless of state, including mid-SEND:
  - force the FSM to IDLE and rr_ptr to 0;
  - clear all outputs to 0 on that edge: grants, done, timeout, valid, reset_SBmessage_retry_timeout, owner_o, busy_o, msg, data;
  - discard any in-flight message with no done or timeout pulse.
REQ-034 The first arbitration after reset release SHALL start at index 0.

Verification
REQ-035 Single request: req_valid_i=0001, sendNext at 3rd SEND cycle -> grant[0] and valid high for 3 cycles, reset_SBmessage_retry_timeout pulses in cycle 1, done[0] pulses 1 cycle, then 1 GAP cycle.
REQ-036 Fairness: req_valid_i=1111 held, sendNext every SEND cycle -> owner sequence 0,1,2,3,0, each grant separated by one GAP and one IDLE cycle.
REQ-037 Timeout: owner 2, timeout_flag=1 with sendNext=0 -> timeout[2] pulses, done stays 0, rr_ptr becomes 3.
REQ-038 Simultaneous: sendNext=1 and timeout_flag=1 in the same cycle -> done pulses, timeout stays 0.
REQ-039 Payload stability: the owner changes req_data_i and drops req_valid_i mid-SEND -> SB_TX_dataBus_o keeps the latched value until done.
REQ-040 Reset mid-SEND: reset=0 while owner 1 is granted -> next cycle all outputs are 0; after release, request 0110 grants index 1 first.
